// File: rtl/song_reader.sv
// song_reader: steps through a song in an external synchronous note ROM, one note per
// ROM entry, with each note lasting a number of beat pulses. A zero duration ends the song.
//   clk         system clock
//   reset       asynchronous active-low reset
//   play        1 = playing, 0 = paused (freezes beat counting only)
//   song        song select, taken when new_song pulses
//   new_song    restart at note 0 of song; highest priority
//   beat        one-cycle beat pulse
//   rom_addr    {song_reg, index} into the note ROM
//   rom_data    {note, duration}, valid the cycle after rom_addr is captured
//   note        current note code
//   new_note    one-cycle strobe when note takes a new value
//   note_active a note is sounding and play is high
//   song_done   end of song reached
module song_reader #(
  parameter int ADDR_W = 7,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic [1:0]              song,
  input  logic                    new_song,
  input  logic                    beat,
  output logic [ADDR_W+1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    new_note,
  output logic                    note_active,
  output logic                    song_done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, PLAYING, DONE} state_t;
  state_t            state, state_nx;
  logic [1:0]        song_reg, song_nx;
  logic [ADDR_W-1:0] index, index_nx;
  logic [DUR_W-1:0]  dur_cnt, dur_nx;
  logic [NOTE_W-1:0] note_nx;
  logic              new_note_nx;
  logic [DUR_W-1:0]  rom_dur;
  logic [NOTE_W-1:0] rom_note;
  assign rom_dur     = rom_data[DUR_W-1:0];
  assign rom_note    = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_addr    = {song_reg, index};
  assign note_active = (state == PLAYING) && play;
  assign song_done   = (state == DONE);
  always_comb begin
    state_nx    = state;
    song_nx     = song_reg;
    index_nx    = index;
    dur_nx      = dur_cnt;
    note_nx     = note;
    new_note_nx = 1'b0;
    if (new_song) begin
      state_nx = IDLE;
      song_nx  = song;
      index_nx = '0;
      dur_nx   = '0;
    end else begin
      case (state)
        IDLE:     state_nx = play ? FETCH : IDLE;
        FETCH:    state_nx = WAIT_ROM;
        WAIT_ROM: begin
          if (rom_dur == '0) begin
            state_nx = DONE;
          end else begin
            note_nx     = rom_note;
            dur_nx      = rom_dur;
            new_note_nx = 1'b1;
            state_nx    = PLAYING;
          end
        end
        PLAYING: begin
          // paused beats are dropped; the last index ends the song instead of wrapping
          if (beat && play) begin
            if (dur_cnt > DUR_W'(1)) dur_nx = dur_cnt - DUR_W'(1);
            else if (&index) state_nx = DONE;
            else begin
              index_nx = index + ADDR_W'(1);
              state_nx = FETCH;
            end
          end
        end
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      song_reg <= '0;
      index    <= '0;
      dur_cnt  <= '0;
      note     <= '0;
      new_note <= 1'b0;
    end else begin
      state    <= state_nx;
      song_reg <= song_nx;
      index    <= index_nx;
      dur_cnt  <= dur_nx;
      note     <= note_nx;
      new_note <= new_note_nx;
    end
  end
endmodule

// File: doc/song_reader.md
# song_reader

Note sequencer that sits directly downstream of the fast-forward-capable beat generator. Consumes its one-cycle `beat` pulses, walks a song stored in an external synchronous note ROM, and presents each note with a `new_note` strobe for the note player. Each note lasts for a number of beats taken from the ROM. Fast-forward is transparent here: faster beats make notes end sooner. A zero duration marks end-of-song.

## Interface
- `ADDR_W`, 7: note-index width; up to 2^ADDR_W notes per song.
- `NOTE_W`, 6: note-code width.
- `DUR_W`, 6: duration width, in beats.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `play`  in  1  level; 1 = playing, 0 = paused.
- `song`  in  2  song select; sampled only on `new_song`.
- `new_song`  in  1  one-cycle pulse; restart at note 0 of `song`.
- `beat`  in  1  one-cycle pulse from the beat generator.
- `rom_addr`  out  2+ADDR_W  {song_reg, index}; combinational from registers.
- `rom_data`  in  NOTE_W+DUR_W  {note, duration}; valid the cycle after `rom_addr` is sampled.
- `note`  out  NOTE_W  current note code; registered.
- `new_note`  out  1  one-cycle pulse when `note` takes a new value.
- `note_active`  out  1  high while a note is sounding and `play`=1.
- `song_done`  out  1  high while in DONE.

## Operation
- Registers: `state`, `song_reg` (2b), `index` (ADDR_W), `dur_cnt` (DUR_W), `note`, `new_note`.
- Reset (`reset`=0, asynchronous):
  - `state`=IDLE.
  - `song_reg`=0, `index`=0, `dur_cnt`=0.
  - `note`=0, `new_note`=0, `note_active`=0, `song_done`=0.
- IDLE: if `play`=1, go to FETCH; otherwise stay.
- FETCH: `rom_addr` = {song_reg, index}. The ROM captures it at the closing edge. Next state is WAIT_ROM.
- WAIT_ROM: `rom_data` is valid.
  - If duration = 0: go to DONE.
  - Otherwise: `note` <= note field, `dur_cnt` <= duration, `new_note` <= 1, go to PLAYING.
- PLAYING: a beat is counted only when `beat`=1 and `play`=1.
  - Counted beat with `dur_cnt` > 1: decrement `dur_cnt`.
  - Counted beat with `dur_cnt` = 1, and `index` < 2^ADDR_W−1: `index`+1, go to FETCH.
  - Counted beat with `dur_cnt` = 1, and `index` = 2^ADDR_W−1: go to DONE. There is no wrap-around.
  - `beat` while `play`=0: ignored, `dur_cnt` held.
- DONE: `song_done`=1, `note_active`=0. Holds until `new_song`; `play` and `beat` are ignored.
- Pause behaviour:
  - FETCH and WAIT_ROM complete regardless of `play`.
  - Pause only freezes beat consumption in PLAYING and deasserts `note_active`.
  - `note` is held during pause.
- `new_song` has top priority in every state and overrides a same-cycle `beat`. On the next edge:
  - `song_reg` <= `song`.
  - `index` <= 0, `dur_cnt` <= 0.
  - `state` <= IDLE.
  - `new_note` <= 0; `note` is held.
- `note_active` = (state == PLAYING) && `play`; combinational.
- `song_done` = (state == DONE); combinational.

## Timing
- `new_note` is high for exactly one cycle: the first PLAYING cycle. `note` changes in that same cycle.
- Latency from a terminating beat (sampled at edge E) to the next note:
  - FETCH in cycle E+1.
  - WAIT_ROM in cycle E+2.
  - `new_note` and the new `note` in cycle E+3.
- Latency from `play` rising in IDLE: `new_note` occurs 3 cycles after `play` is sampled.
- Beats arriving during FETCH or WAIT_ROM are dropped. The beat period must be ≥ 4 cycles at maximum fast-forward; the beat generator guarantees this.
- A note of duration D ends on its D-th counted beat.
- Async reset mid-operation takes effect immediately, with no clock required. Operation resumes from IDLE on the first edge after `reset` returns high.

## Test plan
- Reset: `reset`=0 mid-PLAYING → all outputs 0, state IDLE without a clock edge. After release, `play`=1 → first `new_note` 3 cycles later with `rom_addr`=0.
- Basic song: song 1 ROM = {note 10, dur 2}, {note 20, dur 1}, {x, dur 0}; `play`=1; beat every 10 cycles.
  - `note`=10 with `new_note`; unchanged after beat 1.
  - `note`=20 three cycles after beat 2.
  - `song_done`=1 three cycles after beat 3.
- Pause: during a dur-3 note, `play`=0 across 2 beats, then `play`=1 → ignored beats not counted. `note_active`=0 while paused. The note ends on the 3rd beat counted after resume.
- new_song priority: `new_song` with `song`=2 in the same cycle as a terminating beat → `index`=0, `rom_addr`=0x100 in the next FETCH, no advance of the old song. Also from DONE → `song_done` falls next cycle.
- Index limit: ROM filled with dur-1 notes, no zero marker → after note 127, `song_done`=1 and `rom_addr` never wraps to 0.
- Fast beats: beat pulses every 4 cycles → no note skipped, every `new_note` is exactly one cycle wide.
